// File: rtl/mem_copy_engine.sv
// Block-copy bus initiator for the single-port scratchpad memory.
// Moves len bytes forward from src_addr to dst_addr, one byte every two cycles.
module mem_copy_engine #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              mem_clk,
  input  logic              mem_rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W:0]   len,
  input  logic [DATA_W-1:0] mem_out,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_in,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LP_ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] LP_ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   LP_REM_ZERO  = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   LP_REM_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   LP_REM_FULL  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [DATA_W-1:0] LP_DATA_ZERO = {DATA_W{1'b0}};

  state_t            r_state;
  logic [ADDR_W-1:0] r_src_ptr;
  logic [ADDR_W-1:0] r_dst_ptr;
  logic [ADDR_W:0]   r_remaining;
  logic [DATA_W-1:0] r_data;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_rd_en;
  logic              r_wr_en;
  logic              r_busy;
  logic              r_done;
  logic [ADDR_W:0]   w_len_sat;

  // Any count with the top bit set is treated as a full-memory copy.
  always_comb begin
    w_len_sat = len;
    if (len[ADDR_W]) begin
      w_len_sat = LP_REM_FULL;
    end else begin
      w_len_sat = len;
    end
  end

  // Copy FSM; every output is registered and computed for the state being entered.
  always_ff @(posedge mem_clk or posedge mem_rst) begin
    if (mem_rst) begin
      r_state     <= ST_IDLE;
      r_src_ptr   <= LP_ADDR_ZERO;
      r_dst_ptr   <= LP_ADDR_ZERO;
      r_remaining <= LP_REM_ZERO;
      r_data      <= LP_DATA_ZERO;
      r_mem_addr  <= LP_ADDR_ZERO;
      r_rd_en     <= 1'b0;
      r_wr_en     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_wr_en <= 1'b0;
          r_data  <= LP_DATA_ZERO;
          if (start) begin
            r_src_ptr   <= src_addr;
            r_dst_ptr   <= dst_addr;
            r_remaining <= w_len_sat;
            r_busy      <= 1'b1;
            if (w_len_sat == LP_REM_ZERO) begin
              r_state    <= ST_DONE;
              r_done     <= 1'b1;
              r_rd_en    <= 1'b0;
              r_mem_addr <= LP_ADDR_ZERO;
            end else begin
              r_state    <= ST_READ;
              r_done     <= 1'b0;
              r_rd_en    <= 1'b1;
              r_mem_addr <= src_addr;
            end
          end else begin
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rd_en    <= 1'b0;
            r_mem_addr <= LP_ADDR_ZERO;
          end
        end
        ST_READ: begin
          r_state    <= ST_WRITE;
          r_data     <= mem_out;
          r_rd_en    <= 1'b0;
          r_wr_en    <= 1'b1;
          r_mem_addr <= r_dst_ptr;
        end
        ST_WRITE: begin
          r_src_ptr   <= r_src_ptr + LP_ADDR_ONE;
          r_dst_ptr   <= r_dst_ptr + LP_ADDR_ONE;
          r_remaining <= r_remaining - LP_REM_ONE;
          r_wr_en     <= 1'b0;
          r_data      <= LP_DATA_ZERO;
          if (r_remaining == LP_REM_ONE) begin
            r_state    <= ST_DONE;
            r_done     <= 1'b1;
            r_rd_en    <= 1'b0;
            r_mem_addr <= LP_ADDR_ZERO;
          end else begin
            r_state    <= ST_READ;
            r_done     <= 1'b0;
            r_rd_en    <= 1'b1;
            r_mem_addr <= r_src_ptr + LP_ADDR_ONE;
          end
        end
        ST_DONE: begin
          r_state    <= ST_IDLE;
          r_done     <= 1'b0;
          r_busy     <= 1'b0;
          r_rd_en    <= 1'b0;
          r_wr_en    <= 1'b0;
          r_data     <= LP_DATA_ZERO;
          r_mem_addr <= LP_ADDR_ZERO;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_done     <= 1'b0;
          r_busy     <= 1'b0;
          r_rd_en    <= 1'b0;
          r_wr_en    <= 1'b0;
          r_data     <= LP_DATA_ZERO;
          r_mem_addr <= LP_ADDR_ZERO;
        end
      endcase
    end
  end

  // r_data is cleared outside WRITE so the write bus idles at zero.
  assign mem_addr  = r_mem_addr;
  assign mem_in    = r_data;
  assign mem_rd_en = r_rd_en;
  assign mem_wr_en = r_wr_en;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
